scan_bist_controller: RTL and testbench

//  Built-in self-test sequencer for a scan-inserted ISCAS sequential CUT (default sized for s832: 5 flops, 18 PIs, 19 POs).

---
 rtl/scan_bist_controller.sv | 182 ++++++++++++++++++
 tb/tb_scan_bist_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_bist_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scan_bist_controller
//
// Purpose:
//   Built-in self-test sequencer for a scan-inserted sequential CUT.
//   It generates pseudo-random scan-chain and primary-input patterns from a
//   32-bit LFSR and sequences the shift and capture phases. Scan-out and
//   primary-output responses are compacted into a 32-bit MISR signature.
//
// Ports:
//   CK         in   1      clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   start      in   1      begin a run; only looked at in IDLE
//   busy       out  1      run in progress (SHIFT..DONE inclusive)
//   done       out  1      one-cycle pulse while in DONE
//   scan_en    out  1      1 = CUT flops shift, 0 = functional capture
//   scan_in    out  1      serial data into the chain head
//   scan_out   in   1      serial data from the chain tail
//   pi         out  PI_W   CUT primary inputs
//   po         in   PO_W   CUT primary outputs
//   signature  out  32     current MISR contents
//   pat_cnt    out  16     patterns captured so far in the current run
// -----------------------------------------------------------------------------
module scan_bist_controller #(
  parameter int          CHAIN_LEN    = 5,
  parameter int          NUM_PATTERNS = 64,
  parameter int          PI_W         = 18,
  parameter int          PO_W         = 19,
  parameter logic [31:0] LFSR_SEED    = 32'h1
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            scan_en,
  output logic            scan_in,
  input  logic            scan_out,
  output logic [PI_W-1:0] pi,
  input  logic [PO_W-1:0] po,
  output logic [31:0]     signature,
  output logic [15:0]     pat_cnt
);

  localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting towards the MSB.
  function automatic logic [31:0] poly_step(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       misr_q, misr_d;
  logic [15:0]       pat_cnt_q, pat_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PI_W-1:0]   pi_q, pi_d;
  logic              scan_en_q, scan_en_d;
  logic              scan_in_q, scan_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_last;
  logic [15:0]       pat_cnt_inc;

  assign bit_last    = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));
  assign pat_cnt_inc = pat_cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    pat_cnt_d = pat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pi_d      = pi_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          lfsr_d    = LFSR_SEED;
          misr_d    = '0;
          pat_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        lfsr_d = poly_step(lfsr_q);
        misr_d = poly_step(misr_q) ^ {31'b0, scan_out};
        if (bit_last) begin
          // The pattern's PI slice is taken from the LFSR before it steps.
          pi_d      = lfsr_q[PI_W-1:0];
          bit_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      ST_CAPTURE: begin
        misr_d    = poly_step(misr_q) ^ 32'(po);
        pat_cnt_d = pat_cnt_inc;
        if ({16'd0, pat_cnt_inc} < 32'(NUM_PATTERNS)) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_UNLOAD;
        end
      end

      ST_UNLOAD: begin
        // Flush the last response; the LFSR is left untouched.
        misr_d = poly_step(misr_q) ^ {31'b0, scan_out};
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they belong to, with no input-to-output combinational path.
    scan_en_d = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
    scan_in_d = (state_d == ST_SHIFT) ? lfsr_d[31] : 1'b0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      misr_q    <= '0;
      pat_cnt_q <= '0;
      bit_cnt_q <= '0;
      pi_q      <= '0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      pat_cnt_q <= pat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pi_q      <= pi_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign pi        = pi_q;
  assign signature = misr_q;
  assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_scan_bist_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_scan_bist_controller
//
// Purpose:
//   Self-checking bench for scan_bist_controller. Two instances are used:
//   dut0 (5-flop chain, 4 patterns, 18 PI / 19 PO) and dut1 (1-flop chain,
//   1 pattern). Each drives a small CUT made of a scan shift register whose
//   PO is an XOR of PI, a random mask and the flop contents. Expected
//   signatures come from a serial walk through the pattern/shift/capture
//   schedule using the compaction polynomial.
// -----------------------------------------------------------------------------
module tb_scan_bist_controller;

  logic CK = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- dut0 : CHAIN_LEN=5, NUM_PATTERNS=4 ----------------
  logic        start0 = 1'b0;
  logic        busy0, done0, scan_en0, scan_in0, scan_out0;
  logic [17:0] pi0;
  logic [18:0] po0;
  logic [31:0] sig0;
  logic [15:0] pat0;

  scan_bist_controller #(
    .CHAIN_LEN(5), .NUM_PATTERNS(4), .PI_W(18), .PO_W(19), .LFSR_SEED(32'h1)
  ) dut0 (
    .CK(CK), .RST(RST), .start(start0), .busy(busy0), .done(done0),
    .scan_en(scan_en0), .scan_in(scan_in0), .scan_out(scan_out0),
    .pi(pi0), .po(po0), .signature(sig0), .pat_cnt(pat0)
  );

  logic [4:0]  cut0_q;
  bit          stuck0 = 1'b0;
  bit          po_en0 = 1'b0;
  logic [31:0] mask0  = 32'h0;

  always @(posedge CK) begin
    if (RST) cut0_q <= '0;
    else if (scan_en0) cut0_q <= {cut0_q[3:0], scan_in0};
  end
  assign scan_out0 = stuck0 | cut0_q[4];
  assign po0 = po_en0 ? (19'(pi0) ^ mask0[18:0] ^ 19'(cut0_q)) : 19'd0;

  // ---------------- dut1 : CHAIN_LEN=1, NUM_PATTERNS=1 ----------------
  localparam logic [31:0] SEED1 = 32'hACE1_2345;
  logic        start1 = 1'b0;
  logic        busy1, done1, scan_en1, scan_in1, scan_out1;
  logic [3:0]  pi1;
  logic [2:0]  po1;
  logic [31:0] sig1;
  logic [15:0] pat1;

  scan_bist_controller #(
    .CHAIN_LEN(1), .NUM_PATTERNS(1), .PI_W(4), .PO_W(3), .LFSR_SEED(SEED1)
  ) dut1 (
    .CK(CK), .RST(RST), .start(start1), .busy(busy1), .done(done1),
    .scan_en(scan_en1), .scan_in(scan_in1), .scan_out(scan_out1),
    .pi(pi1), .po(po1), .signature(sig1), .pat_cnt(pat1)
  );

  logic        cut1_q;
  bit          po_en1 = 1'b0;
  logic [31:0] mask1  = 32'h0;

  always @(posedge CK) begin
    if (RST) cut1_q <= 1'b0;
    else if (scan_en1) cut1_q <= scan_in1;
  end
  assign scan_out1 = cut1_q;
  assign po1 = po_en1 ? (3'(pi1) ^ mask1[2:0] ^ {2'b00, cut1_q}) : 3'd0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] poly(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
  endfunction

  function automatic logic [31:0] low_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Walks one complete run bit by bit, starting from an all-zero CUT.
  task automatic ref_run(input int l, input int np, input int piw, input int pow,
                         input logic [31:0] seed, input bit stuck, input bit po_en,
                         input logic [31:0] mask,
                         output logic [31:0] sig, output logic [31:0] last_pi);
    logic [31:0] lf, ms, ch, pv, pov;
    bit so;
    lf = seed; ms = '0; ch = '0; pv = '0;
    for (int p = 0; p < np; p++) begin
      for (int b = 0; b < l; b++) begin
        so = stuck | ch[l-1];
        if (b == l - 1) pv = lf & low_mask(piw);
        ms = poly(ms) ^ {31'b0, so};
        ch = ((ch << 1) | {31'b0, lf[31]}) & low_mask(l);
        lf = poly(lf);
      end
      pov = po_en ? ((pv ^ mask ^ ch) & low_mask(pow)) : 32'h0;
      ms = poly(ms) ^ pov;
    end
    for (int b = 0; b < l; b++) begin
      so = stuck | ch[l-1];
      ms = poly(ms) ^ {31'b0, so};
      ch = (ch << 1) & low_mask(l);
    end
    sig = ms;
    last_pi = pv;
  endtask

  // ---------------- helpers ----------------
  task automatic pulse_start0();
    @(negedge CK); start0 = 1'b1;
    @(posedge CK); #1; start0 = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the start edge) of the
  // next done pulse, or -1 if it did not arrive within the limit.
  task automatic wait_done(input bit which, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CK);
      if ((which == 1'b0 && done0) || (which == 1'b1 && done1)) begin
        cyc = i;
        break;
      end
    end
  endtask

  logic [31:0] golden0;
  logic [31:0] golden_pi0;

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; start0 = 1'b1; start1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CK);
      n_checks++;
      if ({busy0, done0, scan_en0, scan_in0, pi0, sig0, pat0} !== '0) begin
        n_fail++;
        $display("FAIL reset_dut0 cyc%0d: busy=%b done=%b se=%b si=%b pi=%h sig=%h pat=%0d, required all zero",
                 c, busy0, done0, scan_en0, scan_in0, pi0, sig0, pat0);
      end
      n_checks++;
      if ({busy1, done1, scan_en1, scan_in1, pi1, sig1, pat1} !== '0) begin
        n_fail++;
        $display("FAIL reset_dut1 cyc%0d: busy=%b done=%b se=%b sig=%h, required all zero",
                 c, busy1, done1, scan_en1, sig1);
      end
    end
    RST = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CK);
      n_checks++;
      if ({busy0, scan_en0, done0, busy1, scan_en1, done1} !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc%0d: busy0=%b se0=%b done0=%b busy1=%b, required 0",
                 c, busy0, scan_en0, done0, busy1);
      end
    end
  endtask

  task automatic test_timing();
    bit exp_se, exp_busy, exp_done;
    int exp_pat;
    po_en0 = 1'b0; stuck0 = 1'b0;
    pulse_start0();
    for (int n = 1; n <= 31; n++) begin
      @(negedge CK);
      exp_se   = (n <= 29) && ((n % 6) != 0);
      exp_busy = (n <= 30);
      exp_done = (n == 30);
      exp_pat  = ((n - 1) / 6 > 4) ? 4 : (n - 1) / 6;
      n_checks++;
      if ({scan_en0, busy0, done0} !== {exp_se, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL timing_ctrl cyc%0d: se/busy/done=%b%b%b, required %b%b%b",
                 n, scan_en0, busy0, done0, exp_se, exp_busy, exp_done);
      end
      n_checks++;
      if (pat0 !== 16'(exp_pat)) begin
        n_fail++;
        $display("FAIL timing_pat_cnt cyc%0d: got %0d, required %0d", n, pat0, exp_pat);
      end
      if (n >= 25 && n <= 29) begin
        n_checks++;
        if (scan_in0 !== 1'b0) begin
          n_fail++;
          $display("FAIL unload_scan_in cyc%0d: got %b, required 0", n, scan_in0);
        end
      end
    end
    n_checks++;
    if (sig0 !== golden0) begin
      n_fail++;
      $display("FAIL signature_first: got %h, required %h", sig0, golden0);
    end
    n_checks++;
    if (32'(pi0) !== golden_pi0) begin
      n_fail++;
      $display("FAIL last_pi: got %h, required %h", pi0, golden_pi0);
    end
  endtask

  task automatic test_signature_repeat();
    int cyc;
    repeat ($urandom_range(0, 4)) @(negedge CK);
    pulse_start0();
    wait_done(1'b0, 100, cyc);
    n_checks++;
    if (cyc != 30) begin
      n_fail++;
      $display("FAIL repeat_done_cycle: got %0d, required 30", cyc);
    end
    n_checks++;
    if (sig0 !== golden0) begin
      n_fail++;
      $display("FAIL signature_repeat: got %h, required %h", sig0, golden0);
    end
    repeat (3) @(negedge CK);
    n_checks++;
    if (sig0 !== golden0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL signature_hold: sig=%h busy=%b, required sig=%h busy=0", sig0, busy0, golden0);
    end
  endtask

  task automatic test_fault();
    int cyc;
    logic [31:0] exp_sig, exp_pi;
    stuck0 = 1'b1;
    ref_run(5, 4, 18, 19, 32'h1, 1'b1, 1'b0, 32'h0, exp_sig, exp_pi);
    pulse_start0();
    wait_done(1'b0, 100, cyc);
    n_checks++;
    if (cyc != 30) begin
      n_fail++;
      $display("FAIL fault_done_cycle: got %0d, required 30", cyc);
    end
    n_checks++;
    if (sig0 === golden0) begin
      n_fail++;
      $display("FAIL fault_detect: got %h, required a value other than %h", sig0, golden0);
    end
    n_checks++;
    if (sig0 !== exp_sig) begin
      n_fail++;
      $display("FAIL fault_signature: got %h, required %h", sig0, exp_sig);
    end
    stuck0 = 1'b0;
    @(negedge CK);
  endtask

  task automatic test_abort();
    int cyc;
    bit saw_done;
    saw_done = 1'b0;
    pulse_start0();
    for (int n = 1; n <= 11; n++) begin
      @(negedge CK);
      if (done0) saw_done = 1'b1;
    end
    @(negedge CK);           // cycle 12: reset is sampled at the next edge
    if (done0) saw_done = 1'b1;
    RST = 1'b1;
    @(negedge CK);           // cycle 13
    RST = 1'b0;
    n_checks++;
    if ({busy0, done0, scan_en0, scan_in0, pi0, sig0, pat0} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset_values: busy=%b done=%b se=%b si=%b pi=%h sig=%h pat=%0d, required all zero",
               busy0, done0, scan_en0, scan_in0, pi0, sig0, pat0);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge CK);
      if (done0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulse seen=1, required 0");
    end
    pulse_start0();
    wait_done(1'b0, 100, cyc);
    n_checks++;
    if (cyc != 30 || sig0 !== golden0) begin
      n_fail++;
      $display("FAIL abort_rerun: done cycle %0d sig %h, required cycle 30 sig %h", cyc, sig0, golden0);
    end
  endtask

  task automatic test_random_po();
    int cyc;
    logic [31:0] exp_sig, exp_pi;
    for (int it = 0; it < 4; it++) begin
      po_en0 = 1'b1;
      mask0  = $urandom;
      ref_run(5, 4, 18, 19, 32'h1, 1'b0, 1'b1, mask0, exp_sig, exp_pi);
      repeat ($urandom_range(0, 5)) @(negedge CK);
      pulse_start0();
      wait_done(1'b0, 100, cyc);
      n_checks++;
      if (cyc != 30 || sig0 !== exp_sig) begin
        n_fail++;
        $display("FAIL random_po it%0d mask=%h: cycle %0d sig %h, required cycle 30 sig %h",
                 it, mask0, cyc, sig0, exp_sig);
      end
      n_checks++;
      if (32'(pi0) !== exp_pi || pat0 !== 16'd4) begin
        n_fail++;
        $display("FAIL random_po_pi it%0d: pi %h pat %0d, required pi %h pat 4", it, pi0, pat0, exp_pi);
      end
    end
    po_en0 = 1'b0;
  endtask

  task automatic test_boundary();
    bit done_ok;
    logic [31:0] exp_sig, exp_pi;
    po_en1 = 1'b1;
    mask1  = $urandom;
    ref_run(1, 1, 4, 3, SEED1, 1'b0, 1'b1, mask1, exp_sig, exp_pi);
    @(negedge CK); start1 = 1'b1;
    @(posedge CK); #1; start1 = 1'b0;
    done_ok = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge CK);
      if (n == 2) start1 = 1'b1;      // sampled while busy: must be ignored
      if (n == 3) start1 = 1'b0;
      if (done1 !== (n == 4) || busy1 !== (n <= 4)) begin
        done_ok = 1'b0;
        $display("  boundary cyc%0d: done=%b busy=%b", n, done1, busy1);
      end
    end
    n_checks++;
    if (!done_ok) begin
      n_fail++;
      $display("FAIL boundary_timing: done/busy profile wrong, required done only at cycle 4");
    end
    n_checks++;
    if (sig1 !== exp_sig || pat1 !== 16'd1) begin
      n_fail++;
      $display("FAIL boundary_signature: sig %h pat %0d, required sig %h pat 1", sig1, pat1, exp_sig);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [31:0] s1, s2, exp_sig, exp_pi;
    ref_run(1, 1, 4, 3, SEED1, 1'b0, 1'b1, mask1, exp_sig, exp_pi);
    @(negedge CK); start1 = 1'b1;
    @(posedge CK); #1;
    wait_done(1'b1, 20, c1);
    s1 = sig1;
    wait_done(1'b1, 20, c2);
    s2 = sig1;
    @(negedge CK); start1 = 1'b0;
    n_checks++;
    if (c1 != 4 || c2 != 5) begin
      n_fail++;
      $display("FAIL back_to_back_timing: first %0d gap %0d, required first 4 gap 5", c1, c2);
    end
    n_checks++;
    if (s1 !== s2 || s1 !== exp_sig) begin
      n_fail++;
      $display("FAIL back_to_back_signature: %h then %h, required %h twice", s1, s2, exp_sig);
    end
    repeat (12) @(negedge CK);
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_stop: busy=%b, required 0", busy1);
    end
  endtask

  initial begin
    ref_run(5, 4, 18, 19, 32'h1, 1'b0, 1'b0, 32'h0, golden0, golden_pi0);
    test_reset();
    test_timing();
    test_signature_repeat();
    test_fault();
    test_abort();
    test_random_po();
    test_boundary();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
